pdm_mic_tx: RTL and testbench
=============================

Name: pdm_mic_tx

Overview:
- Digital MEMS-microphone emulator: the transmit end of the PDM microphone link that the CIC decimator receives.
- Accepts signed PCM samples over a valid/ready stream into a small FIFO and holds each sample for a programmable number of PDM bits.
- Converts samples to a 1-bit stream with a first-order sigma-delta modulator.
- Drives the bit on the PDM clock phase selected by the channel input, like a real mic; feeds the CIC for closed-loop bring-up and regression.

Parameters:
- DATA_W, 16, PCM sample width, signed two's complement.
- FIFO_DEPTH, 8, sample FIFO entries; power of 2, at least 2.
- HOLD_W, 8, width of hold_num.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  modulator enable.
- pdm_clk  in  1  PDM bit clock, generated synchronously in the clk domain by the CIC clock divider.
- channel  in  1  1=right: drive during pdm_clk high phase; 0=left: drive during low phase.
- hold_num  in  HOLD_W  each sample is emitted for hold_num+1 PDM bits.
- s_data  in  DATA_W  PCM sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  FIFO can accept.
- pdm_data  out  1  PDM bit.
- pdm_oe  out  1  output enable for the shared data line.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- underrun  out  1  sticky; set when a sample is needed and the FIFO is empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (async, rst_n=0), all outputs and state cleared:
  - pdm_data=0, pdm_oe=0, underrun=0, fifo_level=0.
  - s_ready=1, but only after rst_n is released.
  - FIFO empty, acc=0, cur=0, hold_cnt=0, state=IDLE.
  - Reset mid-stream discards FIFO contents and any partial hold.
- Push: when s_valid && s_ready, the sample is written on that clk edge. s_ready = !full.
  - Simultaneous push and pop: occupancy is unchanged; a push is allowed when full only if a pop occurs in the same cycle.
- Edge detect:
  - pclk_q <= pdm_clk every clk.
  - act = en && (channel ? (pdm_clk && !pclk_q) : (!pdm_clk && pclk_q)).
  - All modulator state advances only on act cycles.
- pdm_oe <= en && (pdm_clk == channel): registered, one clk behind the pdm_clk phase.
- Modulator, on act:
  - u = cur with its MSB inverted (offset binary).
  - sum[DATA_W:0] = acc + u (+ dither).
  - pdm_data <= sum[DATA_W]; acc <= sum[DATA_W-1:0].
  - Latency: pdm_data updates on the clk edge after the active pdm_clk edge.
  - The bit always uses the cur value held before any pop in the same cycle.
- State machine (IDLE, RUN):
  - IDLE: cur=0, i.e. 50% ones density. On act with FIFO non-empty: pop into cur, hold_cnt<=0, go to RUN.
  - RUN, act with hold_cnt < hold_num: hold_cnt++.
  - RUN, act with hold_cnt == hold_num:
    - FIFO non-empty: pop into cur, hold_cnt<=0.
    - FIFO empty: underrun<=1, cur<=0, go to IDLE.
  - en=0 in any state: go to IDLE; acc, hold_cnt and cur clear; FIFO retains its contents and still accepts pushes.
- underrun: underrun_clr clears it. If underrun_clr and a new underrun event occur in the same cycle, set wins.
- hold_num is sampled on each act. Changing it mid-hold takes effect on the next comparison.

Optional Feature:
- PDM_TX_DITHER_EN defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset and when en=0.
  - Advances on each act; its output bit is added as carry-in to sum.
- Undefined: carry-in is 0, no LFSR logic, and the output is fully deterministic.

Decomposition:
- Package pdm_mic_tx_pkg: state enum {IDLE, RUN}, LFSR seed and tap constants.
- One natural sub-module: pdm_tx_fifo, a synchronous FIFO with push/pop, full/empty and level.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> pdm_oe=0, pdm_data=0, fifo_level=0, underrun=0 immediately; s_ready=1 after release.
- s_data=0, hold_num=3, channel=1, dither off -> pdm_data sequence after load is 0,1,0,1...; pdm_oe high only during pdm_clk high phase, lagging by 1 clk.
- s_data=16'h7FFF -> first 16 bits are 0 then fifteen 1s. s_data=16'h8000 -> all 0s. channel=0 -> bits update after pdm_clk falling edges.
- FIFO full: with pdm_clk idle, push 9 samples -> s_ready drops after the 8th, 9th not accepted, fifo_level=8.
- Underrun: hold_num=0, push 2 samples, run 4 active edges -> underrun=1 on the 3rd boundary, state IDLE, bits revert to 50% density. Pulse underrun_clr coincident with a new underrun -> underrun stays 1.
- Loopback to CIC: dec_num=63, comb_num=1, s_data=16'h4000 held -> CIC output settles to 48 (64 × 0.75).

Source files
------------

// File: rtl/pdm_mic_tx_pkg.sv
// pdm_mic_tx_pkg: shared types and constants for the PDM microphone emulator.
// Rev 1.0
`default_nettype none

package pdm_mic_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_tx_fifo.sv
// pdm_tx_fifo: synchronous sample FIFO; a push while full succeeds only alongside a pop.
// Rev 1.0
`default_nettype none

module pdm_tx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push_w, do_pop_w;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_pop_w  = pop_i && !empty_o;
  assign do_push_w = push_i && (!full_o || do_pop_w);
  assign data_o    = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push_w) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_w, do_pop_w})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pdm_mic_tx.sv
// pdm_mic_tx: PCM-to-PDM MEMS microphone emulator (FIFO, hold counter, 1st-order sigma-delta).
// Optional LFSR dither carry-in: define PDM_TX_DITHER_EN.  Rev 1.0
`default_nettype none

module pdm_mic_tx
  import pdm_mic_tx_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          pdm_clk_i,
  input  logic                          channel_i,
  input  logic [HOLD_W-1:0]             hold_num_i,
  input  logic [DATA_W-1:0]             s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic                          pdm_data_o,
  output logic                          pdm_oe_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o,
  input  logic                          underrun_clr_i
);

  state_e              state_q, state_d;
  logic                pclk_q, rdy_q, pdm_data_q, pdm_oe_q, underrun_q;
  logic [DATA_W-1:0]   acc_q, cur_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                act_w, hold_done_w, pop_w, hold_inc_w, uset_w, dith_w;
  logic                fifo_full_w, fifo_empty_w, push_w;
  logic [DATA_W-1:0]   fifo_data_w, u_w;
  logic [DATA_W:0]     sum_w;

  assign act_w       = en_i && (channel_i ? (pdm_clk_i && !pclk_q) : (!pdm_clk_i && pclk_q));
  assign hold_done_w = (hold_cnt_q == hold_num_i);
  // s_ready stays low until the first clock after reset release
  assign s_ready_o   = rdy_q && !fifo_full_w;
  assign push_w      = s_valid_i && s_ready_o;

  pdm_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_w),
    .data_i  (s_data_i),
    .pop_i   (pop_w),
    .data_o  (fifo_data_w),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty_w),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else if (act_w) begin
      case (state_q)
        ST_IDLE: if (!fifo_empty_w) state_d = ST_RUN;
        ST_RUN:  if (hold_done_w && fifo_empty_w) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop_w      = 1'b0;
    hold_inc_w = 1'b0;
    uset_w     = 1'b0;
    if (act_w) begin
      case (state_q)
        ST_IDLE: pop_w = !fifo_empty_w;
        ST_RUN: begin
          if (!hold_done_w)       hold_inc_w = 1'b1;
          else if (!fifo_empty_w) pop_w      = 1'b1;
          else                    uset_w     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PDM_TX_DITHER_EN
  logic [15:0] lfsr_q;
  assign dith_w = lfsr_q[0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     lfsr_q <= LFSR_SEED;
    else if (!en_i)  lfsr_q <= LFSR_SEED;
    else if (act_w)  lfsr_q <= {lfsr_q[14:0], lfsr_fb(lfsr_q)};
  end
`else
  assign dith_w = 1'b0;
`endif

  // Offset-binary input: the bit is computed from cur before any same-cycle pop
  assign u_w   = {~cur_q[DATA_W-1], cur_q[DATA_W-2:0]};
  assign sum_w = {1'b0, acc_q} + {1'b0, u_w} + {{DATA_W{1'b0}}, dith_w};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pclk_q     <= 1'b0;
      rdy_q      <= 1'b0;
      pdm_data_q <= 1'b0;
      pdm_oe_q   <= 1'b0;
      underrun_q <= 1'b0;
      acc_q      <= '0;
      cur_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      pclk_q   <= pdm_clk_i;
      rdy_q    <= 1'b1;
      pdm_oe_q <= en_i && (pdm_clk_i == channel_i);
      if (uset_w)              underrun_q <= 1'b1;
      else if (underrun_clr_i) underrun_q <= 1'b0;
      if (!en_i) begin
        acc_q      <= '0;
        cur_q      <= '0;
        hold_cnt_q <= '0;
      end else if (act_w) begin
        pdm_data_q <= sum_w[DATA_W];
        acc_q      <= sum_w[DATA_W-1:0];
        if (pop_w) begin
          cur_q      <= fifo_data_w;
          hold_cnt_q <= '0;
        end else if (hold_inc_w) begin
          hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end else if (uset_w) begin
          cur_q      <= '0;
          hold_cnt_q <= '0;
        end
      end
    end
  end

  assign pdm_data_o = pdm_data_q;
  assign pdm_oe_o   = pdm_oe_q;
  assign underrun_o = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_mic_tx.sv
// tb_pdm_mic_tx: randomized and directed checks of pdm_mic_tx against a sample-level model.
`default_nettype none

module tb_pdm_mic_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int HW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0, pdm_clk = 1'b0, channel = 1'b0, s_valid = 1'b0, uclr = 1'b0;
  logic [HW-1:0] hold_num = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, pdm_data, pdm_oe, underrun;
  logic [3:0]    fifo_level;

  pdm_mic_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .HOLD_W(HW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .pdm_clk_i      (pdm_clk),
    .channel_i      (channel),
    .hold_num_i     (hold_num),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .pdm_data_o     (pdm_data),
    .pdm_oe_o       (pdm_oe),
    .fifo_level_o   (fifo_level),
    .underrun_o     (underrun),
    .underrun_clr_i (uclr)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample queue, integer accumulator, bits remaining in current sample
  int q[$];
  int m_acc, m_cur, m_left;
  bit m_run, m_pclk, m_data, m_oe, m_under, m_rdy;
  logic [15:0] m_lfsr;
  bit pclk_run = 1'b0;
  bit clr_on_act = 1'b0;
  int pdiv = 0;
  int bits[$];

  task automatic model_reset();
    q.delete();
    m_acc = 0; m_cur = 0; m_left = 0; m_run = 0;
    m_pclk = 0; m_data = 0; m_oe = 0; m_under = 0; m_rdy = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic cyc();
    bit act, full, push, uset;
    int sum;
    full = (q.size() == DEPTH);
    push = s_valid && m_rdy && !full;
    act  = en && (channel ? (pdm_clk && !m_pclk) : (!pdm_clk && m_pclk));
    if (clr_on_act && act) uclr = 1'b1;
    @(posedge clk);
    uset = 0;
    if (act) begin
      sum = m_acc + m_cur + 32768;
`ifdef PDM_TX_DITHER_EN
      sum = sum + int'(m_lfsr[0]);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
      m_data = (sum >= 65536);
      m_acc  = sum % 65536;
    end
    if (!en) begin
      m_run = 0; m_cur = 0; m_acc = 0; m_lfsr = 16'hACE1;
    end else if (act) begin
      if (!m_run) begin
        if (q.size() > 0) begin
          m_cur = q.pop_front(); m_left = int'(hold_num); m_run = 1;
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (q.size() > 0) begin
        m_cur = q.pop_front(); m_left = int'(hold_num);
      end else begin
        uset = 1; m_cur = 0; m_run = 0;
      end
    end
    if (push) q.push_back(int'($signed(s_data)));
    if (uset) m_under = 1;
    else if (uclr) m_under = 0;
    m_oe   = en && (pdm_clk == channel);
    m_pclk = pdm_clk;
    m_rdy  = 1;
    #1;
    if (act) bits.push_back(int'(pdm_data));
    check("pdm_data", {31'd0, pdm_data}, {31'd0, m_data});
    check("pdm_oe", {31'd0, pdm_oe}, {31'd0, m_oe});
    check("fifo_level", {28'd0, fifo_level}, q.size());
    check("s_ready", {31'd0, s_ready}, {31'd0, (m_rdy && q.size() != DEPTH)});
    check("underrun", {31'd0, underrun}, {31'd0, m_under});
    if (clr_on_act && act) begin
      uclr = 1'b0;
      clr_on_act = 1'b0;
    end
    if (pclk_run) begin
      pdiv++;
      if (pdiv == 2) begin
        pdiv = 0;
        pdm_clk = ~pdm_clk;
      end
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0; en = 1'b0; uclr = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pdm_data", {31'd0, pdm_data}, 0);
    check("rst_pdm_oe", {31'd0, pdm_oe}, 0);
    check("rst_level", {28'd0, fifo_level}, 0);
    check("rst_underrun", {31'd0, underrun}, 0);
    check("rst_s_ready_low", {31'd0, s_ready}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    check("rst_s_ready_high", {31'd0, s_ready}, 1);
  endtask

  task automatic push(input logic [DW-1:0] d);
    s_valid = 1'b1; s_data = d;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic run_bits(input int n);
    bits.delete();
    for (int k = 0; k < 4000 && bits.size() < n; k++) cyc();
    check("bits_timeout", bits.size(), n);
  endtask

  function automatic int ones(input int from, input int to);
    int c = 0;
    for (int i = from; i < to && i < bits.size(); i++) c += bits[i];
    return c;
  endfunction

  initial begin
    do_reset();
    pclk_run = 1'b1;

    // Zero sample: alternating bits from a cleared accumulator
    hold_num = 8'd3; channel = 1'b1;
    push(16'h0000);
    en = 1'b1;
    run_bits(8);
`ifndef PDM_TX_DITHER_EN
    for (int i = 0; i < bits.size(); i++) check("zero_pattern", bits[i], i % 2);
`endif

    // Full scale positive: load bit from cur=0, then ones
    do_reset();
    hold_num = 8'd255; channel = 1'b1;
    push(16'h7FFF);
    en = 1'b1;
    run_bits(16);
`ifndef PDM_TX_DITHER_EN
    check("max_first", (bits.size() > 0) ? bits[0] : 99, 0);
    check("max_ones", ones(0, 16), 15);
`endif

    // Full scale negative on the left channel: all zeros
    do_reset();
    hold_num = 8'd255; channel = 1'b0;
    push(16'h8000);
    en = 1'b1;
    run_bits(16);
`ifndef PDM_TX_DITHER_EN
    check("min_ones", ones(0, 16), 0);
`endif

    // +0.5 full scale: 75% ones density over 64 bits
    do_reset();
    hold_num = 8'd255; channel = 1'b1;
    push(16'h4000);
    en = 1'b1;
    run_bits(65);
`ifndef PDM_TX_DITHER_EN
    check("density_0p75", ones(1, 65), 48);
`endif

    // FIFO full with pdm_clk idle
    do_reset();
    pclk_run = 1'b0;
    for (int i = 0; i < 9; i++) push(DW'($urandom));
    check("full_level", {28'd0, fifo_level}, DEPTH);
    check("full_ready", {31'd0, s_ready}, 0);
    pclk_run = 1'b1;

    // Underrun on the third boundary, then density returns to 50%
    do_reset();
    hold_num = 8'd0; channel = 1'b1;
    push(16'h1234);
    push(16'hE000);
    en = 1'b1;
    run_bits(2);
    check("under_before", {31'd0, underrun}, 0);
    run_bits(1);
    check("under_set", {31'd0, underrun}, 1);
    run_bits(4);
`ifndef PDM_TX_DITHER_EN
    check("idle_density", ones(0, 4), 2);
`endif
    // Clear coincident with a fresh underrun: set wins
    push(16'h0100);
    run_bits(1);
    clr_on_act = 1'b1;
    run_bits(1);
    check("under_set_wins", {31'd0, underrun}, 1);
    uclr = 1'b1;
    cyc();
    uclr = 1'b0;
    check("under_cleared", {31'd0, underrun}, 0);

    // Randomized traffic, each round ends with a mid-stream reset
    for (int r = 0; r < 6; r++) begin
      en = 1'b0;
      hold_num = HW'($urandom_range(0, 3));
      channel = 1'($urandom);
      cyc();
      en = 1'b1;
      for (int c = 0; c < 300; c++) begin
        s_valid = ($urandom_range(0, 2) == 0);
        s_data  = DW'($urandom);
        uclr    = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 99) == 0) en = ~en;
        cyc();
      end
      uclr = 1'b0;
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
